// File: rtl/display_scan_driver_if.sv
// Bus bundle between a display controller and the seven-segment scan driver.
// The master drives the value to show, the driver reports scan position and segments.
interface display_scan_driver_if;
    logic [31:0] value;
    logic        load;
    logic        blank_lz;
    logic        busy;
    logic [2:0]  digit_sel;
    logic [6:0]  seg;
    logic        frame_done;

    modport master (
        output value,
        output load,
        output blank_lz,
        input  busy,
        input  digit_sel,
        input  seg,
        input  frame_done
    );

    modport slave (
        input  value,
        input  load,
        input  blank_lz,
        output busy,
        output digit_sel,
        output seg,
        output frame_done
    );
endinterface

// File: rtl/display_scan_driver.sv
// Time-multiplexed 8-digit seven-segment scanner with a frame-stable shadow register.
// New values are committed only at the digit-7 -> digit-0 wrap, so a frame never tears.
module display_scan_driver #(
    parameter int REFRESH_DIV = 100_000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    display_scan_driver_if.slave  bus
);
    localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] PCNT_LAST = PW'(REFRESH_DIV - 1);

    logic [PW-1:0] pcnt_reg, pcnt_next;
    logic [2:0]    digit_sel_reg, digit_sel_next;
    logic [31:0]   shadow_reg, shadow_next;
    logic [31:0]   pend_val_reg, pend_val_next;
    logic          pending_reg, pending_next;
    logic          frame_done_reg, frame_done_next;
    logic          blank_lz_reg;

    logic          tick;
    logic          wrap;
    logic [7:0]    upper_zero;
    logic [3:0]    nibble;
    logic          blank_digit;
    logic [6:0]    font;

    assign tick = (pcnt_reg == PCNT_LAST);
    assign wrap = tick && (digit_sel_reg == 3'd7);

    always_comb begin
        pcnt_next       = tick ? '0 : pcnt_reg + PW'(1);
        digit_sel_next  = tick ? digit_sel_reg + 3'd1 : digit_sel_reg;
        frame_done_next = wrap;
        shadow_next     = shadow_reg;
        pend_val_next   = pend_val_reg;
        pending_next    = pending_reg;
        if (wrap) begin
            // A load on the wrap cycle goes straight into the new frame.
            pending_next = 1'b0;
            if (bus.load)
                shadow_next = bus.value;
            else if (pending_reg)
                shadow_next = pend_val_reg;
        end else if (bus.load) begin
            pend_val_next = bus.value;
            pending_next  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt_reg       <= '0;
            digit_sel_reg  <= 3'd0;
            shadow_reg     <= 32'd0;
            pend_val_reg   <= 32'd0;
            pending_reg    <= 1'b0;
            frame_done_reg <= 1'b0;
            blank_lz_reg   <= 1'b0;
        end else begin
            pcnt_reg       <= pcnt_next;
            digit_sel_reg  <= digit_sel_next;
            shadow_reg     <= shadow_next;
            pend_val_reg   <= pend_val_next;
            pending_reg    <= pending_next;
            frame_done_reg <= frame_done_next;
            // Registered so seg has no combinational path from any input.
            blank_lz_reg   <= bus.blank_lz;
        end
    end

    // upper_zero[i]: shadow nibbles i..7 are all zero.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_lz
            assign upper_zero[gi] = (shadow_reg[31:4*gi] == '0);
        end
    endgenerate

    assign nibble      = shadow_reg[{digit_sel_reg, 2'b00} +: 4];
    assign blank_digit = blank_lz_reg && (digit_sel_reg != 3'd0) && upper_zero[digit_sel_reg];

    always_comb begin
        font = 7'b1111111;
        case (nibble)
            4'h0: font = 7'b1000000;
            4'h1: font = 7'b1111001;
            4'h2: font = 7'b0100100;
            4'h3: font = 7'b0110000;
            4'h4: font = 7'b0011001;
            4'h5: font = 7'b0010010;
            4'h6: font = 7'b0000010;
            4'h7: font = 7'b1111000;
            4'h8: font = 7'b0000000;
            4'h9: font = 7'b0010000;
            4'hA: font = 7'b0001000;
            4'hB: font = 7'b0000011;
            4'hC: font = 7'b1000110;
            4'hD: font = 7'b0100001;
            4'hE: font = 7'b0000110;
            4'hF: font = 7'b0001110;
            default: font = 7'b1111111;
        endcase
    end

    assign bus.seg        = blank_digit ? 7'b1111111 : font;
    assign bus.digit_sel  = digit_sel_reg;
    assign bus.busy       = pending_reg;
    assign bus.frame_done = frame_done_reg;
endmodule

// File: tb/tb_display_scan_driver.sv
// Directed bench for display_scan_driver with REFRESH_DIV = 4 (32-cycle frames).
// k counts rising edges since reset release; outputs are sampled on the falling edge.
module tb_display_scan_driver;
    localparam int DIV = 4;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] SA = 7'b0001000;
    localparam logic [6:0] SF = 7'b0001110;
    localparam logic [6:0] SB = 7'b1111111;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   k = 0;
    int   checks = 0;
    int   errors = 0;

    display_scan_driver_if dif ();

    display_scan_driver #(.REFRESH_DIV(DIV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h (k=%0d)", tag, obs, exp, k);
        end
    endtask

    task automatic step();
        @(posedge clk);
        k++;
        @(negedge clk);
    endtask

    task automatic run_to(input int target);
        while (k < target) step();
    endtask

    task automatic load_once(input logic [31:0] v);
        dif.value = v;
        dif.load  = 1'b1;
        step();
        dif.load  = 1'b0;
    endtask

    initial begin
        dif.value    = 32'd0;
        dif.load     = 1'b0;
        dif.blank_lz = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_digit_sel", 32'(dif.digit_sel), 32'd0);
        chk("rst_seg", 32'(dif.seg), 32'(S0));
        chk("rst_busy", 32'(dif.busy), 32'd0);
        chk("rst_frame_done", 32'(dif.frame_done), 32'd0);
        $display("txn reset: digit_sel=%0d seg=%b busy=%0b", dif.digit_sel, dif.seg, dif.busy);

        // Free-running scan for two frames with shadow = 0
        rst_n = 1'b1;
        for (int i = 1; i <= 64; i++) begin
            step();
            chk("scan_digit_sel", 32'(dif.digit_sel), 32'((k / DIV) % 8));
            chk("scan_frame_done", 32'(dif.frame_done), 32'((k % 32) == 0));
            chk("scan_seg", 32'(dif.seg), 32'(S0));
        end
        $display("txn scan: 64 cycles stepped, k=%0d", k);

        // Mid-frame load: current frame keeps old value
        run_to(70);
        load_once(32'h89AB_CDEF);
        chk("load_busy_rise", 32'(dif.busy), 32'd1);
        chk("load_old_seg", 32'(dif.seg), 32'(S0));
        run_to(95);
        chk("load_busy_hold", 32'(dif.busy), 32'd1);
        chk("load_old_seg_d7", 32'(dif.seg), 32'(S0));
        step();
        chk("load_frame_done", 32'(dif.frame_done), 32'd1);
        chk("load_busy_fall", 32'(dif.busy), 32'd0);
        chk("load_d0_F", 32'(dif.seg), 32'(SF));
        run_to(124);
        chk("load_d7_sel", 32'(dif.digit_sel), 32'd7);
        chk("load_d7_8", 32'(dif.seg), 32'(S8));
        $display("txn load 89ABCDEF: d0=F d7=8 seg=%b", dif.seg);

        // Two loads in one frame: latest wins
        run_to(130);
        load_once(32'h1111_1111);
        run_to(140);
        load_once(32'h0000_0042);
        run_to(160);
        chk("twoload_d0", 32'(dif.seg), 32'(S2));
        run_to(164);
        chk("twoload_d1", 32'(dif.seg), 32'(S4));
        run_to(168);
        chk("nolz_d2", 32'(dif.seg), 32'(S0));
        run_to(188);
        chk("nolz_d7", 32'(dif.seg), 32'(S0));
        $display("txn two loads: 00000042 displayed, blank_lz=0");

        // Leading-zero blanking
        dif.blank_lz = 1'b1;
        run_to(192);
        chk("lz_d0", 32'(dif.seg), 32'(S2));
        run_to(196);
        chk("lz_d1", 32'(dif.seg), 32'(S4));
        run_to(200);
        chk("lz_d2", 32'(dif.seg), 32'(SB));
        run_to(220);
        chk("lz_d7", 32'(dif.seg), 32'(SB));
        $display("txn blank_lz=1: digits 2..7 blank");

        // Load exactly on the wrap edge (posedge k=224)
        run_to(223);
        load_once(32'h0000_00A5);
        chk("wrapload_frame_done", 32'(dif.frame_done), 32'd1);
        chk("wrapload_busy", 32'(dif.busy), 32'd0);
        chk("wrapload_d0", 32'(dif.seg), 32'(S5));
        for (int i = 0; i < 4; i++) begin
            step();
            chk("wrapload_busy_low", 32'(dif.busy), 32'd0);
        end
        chk("wrapload_d1", 32'(dif.seg), 32'(SA));
        run_to(232);
        chk("wrapload_d2", 32'(dif.seg), 32'(SB));
        $display("txn load on wrap: 000000A5 shown immediately, busy stayed 0");

        // Reset mid-frame with a load pending
        run_to(240);
        load_once(32'h0000_0777);
        chk("pend_busy", 32'(dif.busy), 32'd1);
        run_to(245);
        rst_n = 1'b0;
        #1;
        chk("arst_digit_sel", 32'(dif.digit_sel), 32'd0);
        chk("arst_busy", 32'(dif.busy), 32'd0);
        chk("arst_seg", 32'(dif.seg), 32'(S0));
        chk("arst_frame_done", 32'(dif.frame_done), 32'd0);
        dif.blank_lz = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        k = 0;
        run_to(4);
        chk("post_rst_sel", 32'(dif.digit_sel), 32'd1);
        run_to(32);
        chk("post_rst_frame_done", 32'(dif.frame_done), 32'd1);
        chk("post_rst_discard", 32'(dif.seg), 32'(S0));
        chk("post_rst_busy", 32'(dif.busy), 32'd0);
        $display("txn reset with pending: pending value discarded");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/display_scan_driver.md
# display_scan_driver

Time-multiplexed scanner for the 8-digit seven-segment display. It holds a 32-bit hexadecimal value in a frame-stable shadow register and steps a 3-bit digit index at a programmable refresh rate. For the current digit it drives the active-low segment pattern. The index output feeds the downstream binary anode decoder directly.

## Interface
- REFRESH_DIV, 100_000: clock cycles per digit slot; must be ≥ 2 (100 MHz gives 1 kHz per digit, 125 Hz per frame).
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- value  input  32  hex value to display; nibble i (value[4i+3:4i]) belongs to digit i.
- load  input  1  single-cycle request to capture `value`.
- blank_lz  input  1  1 = blank leading-zero digits.
- busy  output  1  a loaded value is pending and not yet on the display.
- digit_sel  output  3  current digit index; drives the anode decoder input.
- seg  output  7  {g,f,e,d,c,b,a}, active low.
- frame_done  output  1  one-cycle pulse when the scan wraps from digit 7 to digit 0.

## Operation
- Prescaler `pcnt` counts 0..REFRESH_DIV-1 and wraps to 0. `tick` = (pcnt == REFRESH_DIV-1).
- On `tick`, digit_sel advances by 1 modulo 8. `wrap` = tick & (digit_sel == 7).
- Load path:
  - load = 1 in any cycle: `value` is latched into pend_val and pending is set, unless that cycle is a `wrap`.
  - Repeated loads before commit overwrite pend_val. The latest load wins.
- Commit at `wrap`:
  - load = 1 in the same cycle: shadow ← value, pending ← 0.
  - else if pending = 1: shadow ← pend_val, pending ← 0.
  - else: shadow unchanged.
  - The display never changes mid-frame.
- busy = pending.
- Segment decode uses nibble n = shadow[4·digit_sel+3 -: 4], hex font, active low:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000
  - 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000
  - 8 = 0000000, 9 = 0010000, A = 0001000, b = 0000011
  - C = 1000110, d = 0100001, E = 0000110, F = 0001110
  - blank = 1111111
- Leading-zero blanking:
  - Digit i (i ≥ 1) is blanked when blank_lz = 1 and shadow nibbles i..7 are all zero.
  - Digit 0 is never blanked.
  - blank_lz is sampled live, with no frame alignment.
- seg always corresponds to the current digit_sel and current shadow. There is no skew between them.
- digit_sel, busy and frame_done are registered outputs. seg may be decoded combinationally from registered state only; no input-to-output path.

## Timing
- Reset values:
  - pcnt = 0, digit_sel = 0, shadow = 0, pend_val = 0, pending/busy = 0, frame_done = 0.
  - seg = 1000000 (digit 0 shows "0").
- digit_sel holds each value for exactly REFRESH_DIV cycles. A full frame is 8·REFRESH_DIV cycles.
- frame_done is high for the single cycle immediately after the `wrap` edge, coincident with digit_sel = 0 and the new shadow.
- A load is visible on seg no earlier than the first cycle of the next frame. Worst-case latency is 8·REFRESH_DIV cycles after the load.
- busy rises the cycle after a load (non-wrap cycle) and falls the cycle after the committing wrap.
- Reset asserted mid-frame or with a load pending: all state clears immediately, and the pending value is discarded.
- Reset release: counting starts on the first clk edge with rst_n = 1.

## Test plan
- Reset, no load, REFRESH_DIV = 4:
  - digit_sel steps 0..7, each held 4 cycles.
  - seg = 1000000 on every digit.
  - frame_done pulses every 32 cycles, coincident with digit_sel = 0.
- load value = 32'h89AB_CDEF mid-frame:
  - busy = 1 until the next wrap.
  - Next frame shows digit 0 = 0001110 (F) and digit 7 = 0000000 (8).
  - The current frame keeps the old value.
- Two loads in one frame (32'h1111_1111 then 32'h0000_0042):
  - Only 32'h42 is displayed next frame.
- value = 32'h0000_0042, blank_lz = 1:
  - Digits 2..7 = 1111111, digit 1 = 0011001, digit 0 = 0100100.
  - With blank_lz = 0, digits 2..7 = 1000000.
- load asserted exactly on the wrap cycle:
  - Value appears in the frame starting that edge.
  - busy never rises.
- rst_n pulsed low mid-frame with busy = 1:
  - Outputs return to reset values asynchronously.
  - The pending value is never displayed.
